// File: rtl/fir_pkg.sv
// Shared FIR-side definitions: default data width, tap count and the state
// encodings used by the I2S feeder FSMs.
package fir_pkg;

    localparam int FIR_WIDTH = 24;
    localparam int FIR_TAPS  = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } des_state_t;

    typedef enum logic {
        B_IDLE = 1'b0,
        B_RUN  = 1'b1
    } burst_state_t;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_rx_feeder_if.sv
// FIR-facing bundle of the I2S feeder: sample, step enable, strobes and flags.
interface i2s_rx_feeder_if
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH
);

    logic signed [WIDTH-1:0] input_sig;
    logic                    ready;
    logic                    sample_valid;
    logic                    overrun;
    logic                    frame_err;
    logic                    clr_flags;

    modport master (
        output input_sig,
        output ready,
        output sample_valid,
        output overrun,
        output frame_err,
        input  clr_flags
    );

    modport slave (
        input  input_sig,
        input  ready,
        input  sample_valid,
        input  overrun,
        input  frame_err,
        output clr_flags
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing one asynchronous bit into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/i2s_rx_feeder.sv
// Captures one I2S slot per frame and presents each accepted word to the FIR
// for a burst of TAPS consecutive step enables.
module i2s_rx_feeder
    import fir_pkg::*;
#(
    parameter int WIDTH   = FIR_WIDTH,
    parameter int TAPS    = FIR_TAPS,
    parameter int CHANNEL = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i2s_sck,
    input  logic            i2s_ws,
    input  logic            i2s_sd,
    i2s_rx_feeder_if.master fir
);

    localparam int              CW       = cnt_width(TAPS);
    localparam int              BW       = cnt_width(WIDTH);
    localparam logic            CH_WS    = (CHANNEL != 0) ? 1'b1 : 1'b0;
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0]   LAST_TAP = CW'(TAPS - 1);

    logic sck_s, ws_s, sd_s;
    logic sck_d_r, ws_d_r;
    logic sck_rise_s, ws_tog_s, slot_start_s, done_s, ferr_set_s;
    logic [WIDTH-1:0] word_s;

    des_state_t              des_state_r;
    logic [BW-1:0]           bit_cnt_r;
    logic [WIDTH-1:0]        shift_r;
    logic                    frame_err_r;

    burst_state_t            burst_r;
    logic [CW-1:0]           tap_cnt_r;
    logic                    ready_r;
    logic                    sample_valid_r;
    logic                    overrun_r;
    logic signed [WIDTH-1:0] input_sig_r;

    sync_2ff u_sync_sck (.clk(clk), .rst_n(rst_n), .d(i2s_sck), .q(sck_s));
    sync_2ff u_sync_ws  (.clk(clk), .rst_n(rst_n), .d(i2s_ws),  .q(ws_s));
    sync_2ff u_sync_sd  (.clk(clk), .rst_n(rst_n), .d(i2s_sd),  .q(sd_s));

    // Previous synchronised sck/ws for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_d_r <= 1'b0;
            ws_d_r  <= 1'b0;
        end else begin
            sck_d_r <= sck_s;
            ws_d_r  <= ws_s;
        end
    end

    // Edge events, next shift value and word-complete strobe
    always_comb begin
        sck_rise_s   = sck_s & ~sck_d_r;
        ws_tog_s     = ws_s ^ ws_d_r;
        slot_start_s = ws_tog_s & (ws_s == CH_WS);
        word_s       = (shift_r << 1) | WIDTH'(sd_s);
        ferr_set_s   = ws_tog_s & ((des_state_r == SKIP) | (des_state_r == SHIFT));
        done_s       = (des_state_r == SHIFT) & ~ws_tog_s & sck_rise_s & (bit_cnt_r == LAST_BIT);
    end

    // Deserialiser: slot alignment, MSB-first shift and framing error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            des_state_r <= IDLE;
            bit_cnt_r   <= {BW{1'b0}};
            shift_r     <= {WIDTH{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            case (des_state_r)
                IDLE: begin
                    if (slot_start_s) begin
                        des_state_r <= SKIP;
                    end else begin
                        des_state_r <= IDLE;
                    end
                end
                SKIP: begin
                    // A toggle here may itself be a new slot start
                    if (ws_tog_s) begin
                        des_state_r <= slot_start_s ? SKIP : IDLE;
                    end else if (sck_rise_s) begin
                        des_state_r <= SHIFT;
                        bit_cnt_r   <= {BW{1'b0}};
                    end else begin
                        des_state_r <= SKIP;
                    end
                end
                SHIFT: begin
                    if (ws_tog_s) begin
                        des_state_r <= slot_start_s ? SKIP : IDLE;
                    end else if (sck_rise_s) begin
                        shift_r <= word_s;
                        if (bit_cnt_r == LAST_BIT) begin
                            des_state_r <= HOLD;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end else begin
                        des_state_r <= SHIFT;
                    end
                end
                HOLD: begin
                    if (ws_tog_s) begin
                        des_state_r <= IDLE;
                    end else begin
                        des_state_r <= HOLD;
                    end
                end
                default: des_state_r <= IDLE;
            endcase

            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (fir.clr_flags) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    // Sample hand-off and TAPS-cycle ready burst; words arriving mid-burst are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_r        <= B_IDLE;
            tap_cnt_r      <= {CW{1'b0}};
            ready_r        <= 1'b0;
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
            input_sig_r    <= {WIDTH{1'b0}};
        end else begin
            sample_valid_r <= 1'b0;
            if (done_s && (burst_r == B_IDLE) && !sample_valid_r) begin
                input_sig_r    <= word_s;
                sample_valid_r <= 1'b1;
            end else if (done_s) begin
                overrun_r <= 1'b1;
            end else if (fir.clr_flags) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end

            case (burst_r)
                B_IDLE: begin
                    if (sample_valid_r) begin
                        burst_r   <= B_RUN;
                        tap_cnt_r <= {CW{1'b0}};
                        ready_r   <= 1'b1;
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                B_RUN: begin
                    if (tap_cnt_r == LAST_TAP) begin
                        burst_r   <= B_IDLE;
                        tap_cnt_r <= {CW{1'b0}};
                        ready_r   <= 1'b0;
                    end else begin
                        tap_cnt_r <= tap_cnt_r + 1'b1;
                        ready_r   <= 1'b1;
                    end
                end
                default: begin
                    burst_r <= B_IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign fir.input_sig    = input_sig_r;
    assign fir.ready        = ready_r;
    assign fir.sample_valid = sample_valid_r;
    assign fir.overrun      = overrun_r;
    assign fir.frame_err    = frame_err_r;

endmodule

// File: tb/tb_i2s_rx_feeder.sv
// Randomised I2S stimulus into a left-slot and a right-slot feeder, checked
// against a frame-level reference model of accepted words, bursts and flags.
module tb_i2s_rx_feeder;

    localparam int W = 24;
    localparam int T = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic ws = 1'b0;
    logic sd = 1'b0;
    int   cyc = 0;

    i2s_rx_feeder_if #(.WIDTH(W)) if0 ();
    i2s_rx_feeder_if #(.WIDTH(W)) if1 ();

    i2s_rx_feeder #(.WIDTH(W), .TAPS(T), .CHANNEL(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd), .fir(if0)
    );
    i2s_rx_feeder #(.WIDTH(W), .TAPS(T), .CHANNEL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd), .fir(if1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed sample strobes, burst lengths and hold violations per feeder
    logic [W-1:0] got0_q[$], got1_q[$];
    int           runs0_q[$], runs1_q[$];
    int           run0 = 0, run1 = 0, unstable0 = 0, unstable1 = 0;
    logic [W-1:0] held0 = '0, held1 = '0;

    always @(negedge clk) begin
        if (if0.sample_valid) begin
            got0_q.push_back(if0.input_sig);
            held0 <= if0.input_sig;
        end
        if (if0.ready) begin
            run0 <= run0 + 1;
            if ($unsigned(if0.input_sig) !== held0) unstable0 <= unstable0 + 1;
        end else if (run0 > 0) begin
            runs0_q.push_back(run0);
            run0 <= 0;
        end
    end

    always @(negedge clk) begin
        if (if1.sample_valid) begin
            got1_q.push_back(if1.input_sig);
            held1 <= if1.input_sig;
        end
        if (if1.ready) begin
            run1 <= run1 + 1;
            if ($unsigned(if1.input_sig) !== held1) unstable1 <= unstable1 + 1;
        end else if (run1 > 0) begin
            runs1_q.push_back(run1);
            run1 <= 0;
        end
    end

    // Reference model: a completed word is accepted only if the previous
    // accepted word's strobe and TAPS-cycle burst (starting one cycle later) are over.
    logic [W-1:0] exp0_q[$], exp1_q[$];
    int           last_acc[2];
    logic         have_acc[2];
    logic         eovr[2];
    logic         eferr[2];
    int           bg[2], be[2], br[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            have_acc[c] = 1'b0;
            eovr[c]     = 1'b0;
            eferr[c]    = 1'b0;
        end
    endtask

    task automatic model_done(input int ch, input logic [W-1:0] word, input int at);
        if (!have_acc[ch] || (at - last_acc[ch]) >= T + 2) begin
            if (ch == 0) exp0_q.push_back(word);
            else         exp1_q.push_back(word);
            last_acc[ch] = at;
            have_acc[ch] = 1'b1;
        end else begin
            eovr[ch] = 1'b1;
        end
    endtask

    task automatic rebase();
        bg[0] = got0_q.size();  bg[1] = got1_q.size();
        be[0] = exp0_q.size();  be[1] = exp1_q.size();
        br[0] = runs0_q.size(); br[1] = runs1_q.size();
    endtask

    // One slot: delay bit, then the word MSB first, then filler bits
    task automatic drive_slot(input int ch, input logic [W-1:0] word, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sck = 1'b0;
            ws  = (ch != 0);
            sd  = (i >= 1 && i <= W) ? word[W-i] : 1'($urandom);
            repeat (half - 1) @(negedge clk);
            @(negedge clk);
            sck = 1'b1;
            if (i == W) model_done(ch, word, cyc);
            repeat (half - 1) @(negedge clk);
        end
        if (nbits <= W) eferr[ch] = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] right, input logic [W-1:0] left,
                              input int rbits, input int lbits, input int half);
        drive_slot(1, right, rbits, half);
        drive_slot(0, left, lbits, half);
    endtask

    task automatic check_dut(input string tag, input int ch);
        int ng, ne, nr;
        ng = (ch == 0) ? got0_q.size() - bg[0] : got1_q.size() - bg[1];
        ne = (ch == 0) ? exp0_q.size() - be[0] : exp1_q.size() - be[1];
        nr = (ch == 0) ? runs0_q.size() - br[0] : runs1_q.size() - br[1];
        check_val({tag, "/sv_count"}, ng, ne);
        for (int i = 0; i < ng && i < ne; i++) begin
            check_val({tag, "/sample"},
                      (ch == 0) ? got0_q[bg[0] + i] : got1_q[bg[1] + i],
                      (ch == 0) ? exp0_q[be[0] + i] : exp1_q[be[1] + i]);
        end
        check_val({tag, "/bursts"}, nr, ne);
        for (int i = 0; i < nr; i++) begin
            check_val({tag, "/burst_len"}, (ch == 0) ? runs0_q[br[0] + i] : runs1_q[br[1] + i], T);
        end
        check_val({tag, "/overrun"},   (ch == 0) ? if0.overrun   : if1.overrun,   eovr[ch]);
        check_val({tag, "/frame_err"}, (ch == 0) ? if0.frame_err : if1.frame_err, eferr[ch]);
        check_val({tag, "/hold"},      (ch == 0) ? unstable0     : unstable1,     0);
    endtask

    task automatic check_scn(input string tag);
        repeat (T + 80) @(negedge clk);
        check_dut({tag, "/L"}, 0);
        check_dut({tag, "/R"}, 1);
        rebase();
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        if0.clr_flags = 1'b1;
        if1.clr_flags = 1'b1;
        @(negedge clk);
        if0.clr_flags = 1'b0;
        if1.clr_flags = 1'b0;
        for (int c = 0; c < 2; c++) begin
            eovr[c]  = 1'b0;
            eferr[c] = 1'b0;
        end
        @(negedge clk);
        check_val("clr/L_ovr",  if0.overrun,   1'b0);
        check_val("clr/L_ferr", if0.frame_err, 1'b0);
        check_val("clr/R_ovr",  if1.overrun,   1'b0);
        check_val("clr/R_ferr", if1.frame_err, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "/L_sig"},  $unsigned(if0.input_sig), 0);
        check_val({tag, "/L_rdy"},  if0.ready,        1'b0);
        check_val({tag, "/L_sv"},   if0.sample_valid, 1'b0);
        check_val({tag, "/L_ovr"},  if0.overrun,      1'b0);
        check_val({tag, "/L_ferr"}, if0.frame_err,    1'b0);
        check_val({tag, "/R_sig"},  $unsigned(if1.input_sig), 0);
        check_val({tag, "/R_rdy"},  if1.ready,        1'b0);
        check_val({tag, "/R_sv"},   if1.sample_valid, 1'b0);
        check_val({tag, "/R_ovr"},  if1.overrun,      1'b0);
        check_val({tag, "/R_ferr"}, if1.frame_err,    1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        int           k;

        if0.clr_flags = 1'b0;
        if1.clr_flags = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rebase();

        // Known words, generous frame: left capture and right-only capture
        send_frame(24'hABCDEF, 24'h800001, 32, 32, 4);
        check_scn("basic1");
        send_frame(24'hABCDEF, 24'h123456, 32, 32, 4);
        check_scn("basic2");

        // Random words, rates and slot lengths
        for (int f = 0; f < 4; f++) begin
            send_frame(W'($urandom), W'($urandom), $urandom_range(W + 1, 32),
                       $urandom_range(W + 1, 32), $urandom_range(2, 4));
        end
        check_scn("random");

        // Fast frames at 4x clk: second left word lands inside the burst
        send_frame(W'($urandom), W'($urandom), 1, 31, 2);
        send_frame(W'($urandom), W'($urandom), 1, 31, 2);
        check_scn("overrun");
        pulse_clr();

        // Truncated left slot, then a normal frame
        send_frame(W'($urandom), W'($urandom), 32, 11, 4);
        send_frame(W'($urandom), W'($urandom), 32, 32, 4);
        check_scn("framing");
        pulse_clr();
        rebase();

        // Reset at burst cycle 50
        w = W'($urandom);
        send_frame(W'($urandom), w, 32, 32, 4);
        k = 0;
        while (!if0.ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val("rst/burst_start", if0.ready, 1'b1);
        repeat (50) @(negedge clk);
        check_val("rst/pre_ready", if0.ready, 1'b1);
        check_val("rst/pre_sample", $unsigned(if0.input_sig), w);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rebase();
        send_frame(W'($urandom), W'($urandom), 32, 32, 4);
        check_scn("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
